csi_detrend: RTL
================

# csi_detrend

Windowed mean-removal filter for the CSI extraction path, the high-pass complement of the moving-average smoother. Each accepted sample enters a power-of-two window. Once the window is full, the block emits the window's centre sample minus the floored window mean. It sits after the per-subcarrier amplitude/phase stage and feeds detrended samples downstream with ready/valid backpressure.

## Interface
- DATA_WIDTH, 32: signed input sample width.
- WINDOW_SHIFT, 4: log2 of the window size W; must be ≥ 1.
- clk_in  input  1: the single clock.
- rst_in  input  1: synchronous, active-high reset.
- data_in  input  DATA_WIDTH: signed sample.
- data_in_valid  input  1: data_in is valid this cycle.
- data_in_ready  output  1: the block can accept a sample this cycle.
- data_out  output  DATA_WIDTH+1: signed detrended sample.
- data_out_valid  output  1: data_out is valid.
- data_out_ready  input  1: downstream accepts data_out this cycle.

## Operation
- Accept: a sample is accepted on a cycle where data_in_valid && data_in_ready.
- Ready rule: data_in_ready = !data_out_valid || data_out_ready, combinational.
- Window storage: ring buffer of W entries with a WINDOW_SHIFT-bit write pointer addr.
  - Each accept writes buffer[addr] and then increments addr; it wraps modulo W.
- State machine, two states:
  - FILL is the reset state. On the accept that writes addr == W-1, move to RUN.
  - RUN is left only by reset.
- Running sum: signed, DATA_WIDTH+WINDOW_SHIFT bits.
  - new_sum = sum + data_in − (RUN ? buffer[addr] : 0). buffer[addr] is read before it is overwritten.
- Centre sample: buffer[addr + W/2] (mod W), read before the write.
  - This is x[n−W/2] for the sample index n being accepted.
- Output generation: produced only on accepts where either the state is RUN or addr == W-1.
  - data_out <= centre − (new_sum >>> WINDOW_SHIFT). The shift is arithmetic, so the mean floors toward −∞.
  - The result is computed at DATA_WIDTH+1 bits, so no overflow is possible.
- Accepts in FILL with addr < W-1 update the sum and buffer only; no output is produced.
- Output hold: data_out and data_out_valid hold while data_out_valid && !data_out_ready.
- Reset mid-operation clears the pointer, the sum, all buffer entries, the state and the output register. Any pending output is dropped.

## Timing
- Reset values: data_out = 0, data_out_valid = 0, data_in_ready = 1 (follows from the ready rule), state = FILL, addr = 0, sum = 0.
- Latency: data_out_valid rises 1 cycle after a producing accept.
- First output: follows the W-th accepted sample and equals x[W/2−1] − floor(Σx[0..W−1]/W).
- Throughput: 1 sample/cycle while data_out_ready is high.
- Simultaneous events: when data_out is consumed on the same cycle a new sample is accepted, the output register reloads with no bubble.
- When data_out_valid is high and data_out_ready is low, data_in_ready is 0. No sample is accepted and no state changes.
- Gaps in data_in_valid do not alter window contents.

## Configuration
- CSI_DETREND_SAT_EN defined:
  - The DATA_WIDTH+1-bit result is clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] before registering.
  - The clamped value is sign-extended onto data_out.
- CSI_DETREND_SAT_EN undefined: the full DATA_WIDTH+1-bit result is output.
- Port widths are identical in both builds.

## Structure
- Package csi_detrend_pkg holds:
  - typedef enum logic {FILL, RUN} detrend_state_t;
  - helper function sat_signed, used under CSI_DETREND_SAT_EN.
- Sub-module csi_window_ram: W×DATA_WIDTH ring storage.
  - One write port and two asynchronous read ports (oldest, centre).
  - Synchronous reset clears all entries.

## Test plan
All cases use WINDOW_SHIFT=2 (W=4) unless stated.
- Ramp: inputs 4, 8, 12, 16, 20 with data_out_ready=1 → outputs −2 (after 16; sum 40, centre 8), then −2 (after 20; sum 56, centre 12). No output before the 4th sample.
- Constant: input 100 for 10 samples → seven outputs, all 0.
- Floor check: inputs −1, 0, 0, 0 → output +1 (mean = −1).
- Saturation, DATA_WIDTH=8: inputs −128, 127, −128, −128 (sum −257, mean −65, centre 127).
  - Without the macro the output is +192.
  - With CSI_DETREND_SAT_EN the output is +127.
- Backpressure: hold data_out_ready=0 for 5 cycles after the first output while data_in_valid=1.
  - data_in_ready must stay 0 and data_out stay stable.
  - After release, the sequence continues with no loss or duplication.
- Reset mid-run: assert rst_in for 1 cycle after 6 samples, with an output pending.
  - data_out_valid must be 0 next cycle.
  - The next output appears only after 4 new samples and reflects only post-reset data.

Source files
------------

// File: rtl/csi_detrend_pkg.sv
// Shared types and helpers for the csi_detrend windowed mean-removal filter.
// sat_signed is only referenced when CSI_DETREND_SAT_EN is defined.
package csi_detrend_pkg;

  typedef enum logic {FILL, RUN} detrend_state_t;

  localparam int SAT_W = 96;

  // Clamp a sign-extended value into the signed range of a w-bit word (w < SAT_W).
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/csi_window_ram.sv
// W x DATA_WIDTH ring storage: one write port, two asynchronous read ports
// (oldest entry and centre entry); synchronous reset clears every entry.
module csi_window_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     old_addr,
  output logic [DATA_WIDTH-1:0] old_data,
  input  logic [ADDR_W-1:0]     ctr_addr,
  output logic [DATA_WIDTH-1:0] ctr_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Reads return pre-write contents, so the evicted sample is still visible.
  assign old_data = mem[old_addr];
  assign ctr_data = mem[ctr_addr];

endmodule

// File: rtl/csi_detrend.sv
// Windowed mean-removal: emits centre sample minus floored window mean once
// the window is full. Define CSI_DETREND_SAT_EN to clamp results to DATA_WIDTH.
module csi_detrend
  import csi_detrend_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int WINDOW_SHIFT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH:0]   data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  // Handshake: a transfer happens on any cycle where valid && ready; the
  // producer holds its data stable while valid is high and ready is low.

  localparam int W     = 1 << WINDOW_SHIFT;
  localparam int SUM_W = DATA_WIDTH + WINDOW_SHIFT;
  localparam logic [WINDOW_SHIFT-1:0] LAST = WINDOW_SHIFT'(W - 1);
  localparam logic [WINDOW_SHIFT-1:0] HALF = WINDOW_SHIFT'(W / 2);

  detrend_state_t              state;
  detrend_state_t              state_d;
  logic [WINDOW_SHIFT-1:0]     addr;
  logic signed [SUM_W-1:0]     sum;
  logic signed [SUM_W-1:0]     new_sum;
  logic signed [SUM_W-1:0]     old_term;
  logic signed [SUM_W-1:0]     mean;
  logic [DATA_WIDTH-1:0]       old_data;
  logic [DATA_WIDTH-1:0]       ctr_data;
  logic [DATA_WIDTH:0]         result;
  logic [DATA_WIDTH:0]         next_out;
  logic                        accept;
  logic                        produce;

  assign data_in_ready = !data_out_valid || data_out_ready;
  assign accept        = data_in_valid && data_in_ready;

  csi_window_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (WINDOW_SHIFT)
  ) u_ram (
    .clk      (clk_in),
    .rst      (rst_in),
    .wr_en    (accept),
    .wr_addr  (addr),
    .wr_data  (data_in),
    .old_addr (addr),
    .old_data (old_data),
    .ctr_addr (addr + HALF),
    .ctr_data (ctr_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= FILL;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    produce = 1'b0;
    if (accept) begin
      if (state == RUN) begin
        produce = 1'b1;
      end else if (addr == LAST) begin
        produce = 1'b1;
        state_d = RUN;
      end
    end
  end

  always_comb begin
    old_term = (state == RUN) ? {{WINDOW_SHIFT{old_data[DATA_WIDTH-1]}}, old_data} : '0;
    new_sum  = sum + {{WINDOW_SHIFT{data_in[DATA_WIDTH-1]}}, data_in} - old_term;
    mean     = new_sum >>> WINDOW_SHIFT;
    // The mean of DATA_WIDTH-bit samples always fits in DATA_WIDTH+1 bits.
    result   = {ctr_data[DATA_WIDTH-1], ctr_data} - mean[DATA_WIDTH:0];
  end

`ifdef CSI_DETREND_SAT_EN
  logic signed [SAT_W-1:0] wide;
  logic signed [SAT_W-1:0] clamped;
  always_comb begin
    wide     = {{(SAT_W - DATA_WIDTH - 1){result[DATA_WIDTH]}}, result};
    clamped  = sat_signed(wide, DATA_WIDTH);
    next_out = clamped[DATA_WIDTH:0];
  end
`else
  assign next_out = result;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr <= '0;
      sum  <= '0;
    end else if (accept) begin
      addr <= addr + 1'b1;
      sum  <= new_sum;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (data_in_ready) begin
      if (produce) begin
        data_out       <= next_out;
        data_out_valid <= 1'b1;
      end else begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule
